ct_l2cache_data_array_bank_ctrl: RTL and testbench

- Next-generation L2 data array: a parametrised, multi-bank, single-port SRAM data store with a request/ready handshake.
- Replaces the fixed single-macro 128-bit array.
- Sits between the L2 data pipeline and the SRAM macros.
- Adds:
  - bank interleaving
  - per-bank cycle-time enforcement
  - configurable read latency
  - a hardware zero-init sequencer after reset or on demand

---
 rtl/ct_l2cache_data_pkg.sv | 23 ++
 rtl/ct_l2cache_data_bank.sv | 31 +++
 rtl/ct_l2cache_data_array_bank_ctrl.sv | 175 +++++++++++++++++
 tb/tb_ct_l2cache_data_array_bank_ctrl.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/ct_l2cache_data_pkg.sv
// Shared definitions for the banked L2 data array: default geometry,
// derived widths and the controller state encoding.
package ct_l2cache_data_pkg;

   localparam int DATA_WIDTH_DEF  = 128;
   localparam int INDEX_WIDTH_DEF = 13;
   localparam int BANK_NUM_DEF    = 4;

   // Derived geometry for the default configuration
   localparam int BANK_BITS = (BANK_NUM_DEF <= 1) ? 0 : $clog2(BANK_NUM_DEF);
   localparam int ROW_WIDTH = INDEX_WIDTH_DEF - BANK_BITS;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   // Number of index bits used for bank selection (0 for a single bank)
   function automatic int bank_bits(input int n);
      return (n <= 1) ? 0 : $clog2(n);
   endfunction

endpackage

// File: rtl/ct_l2cache_data_bank.sv
// Behavioural single-port SRAM bank, active-low controls, bit-write mask.
// Stands in for the per-configuration macro.
module ct_l2cache_data_bank #(
   parameter int DATA_WIDTH = 128,
   parameter int ROW_WIDTH  = 11
) (
   input  logic                  clk,
   input  logic                  pad_yy_icg_scan_en,
   input  logic                  cen,
   input  logic                  gwen,
   input  logic [DATA_WIDTH-1:0] wen,
   input  logic [ROW_WIDTH-1:0]  a,
   input  logic [DATA_WIDTH-1:0] d,
   output logic [DATA_WIDTH-1:0] q
);

   logic [DATA_WIDTH-1:0] mem [2**ROW_WIDTH];
   logic                  clk_en;

   // Macro clock-gate enable: opens on chip select or under scan
   assign clk_en = ~cen | pad_yy_icg_scan_en;

   // Array access: masked write keeps bits whose wen is high, read updates Q
   always_ff @(posedge clk) begin
      if (clk_en && !cen) begin
         if (!gwen) mem[a] <= (mem[a] & wen) | (d & ~wen);
         else       q      <= mem[a];
      end
   end

endmodule

// File: rtl/ct_l2cache_data_array_bank_ctrl.sv
// Banked L2 data array controller: bank interleaving, per-bank cycle-time
// enforcement, fixed read latency and a hardware zero-fill sequencer.
module ct_l2cache_data_array_bank_ctrl
   import ct_l2cache_data_pkg::*;
#(
   parameter int DATA_WIDTH  = 128,
   parameter int INDEX_WIDTH = 13,
   parameter int BANK_NUM    = 4,
   parameter int BANK_CYCLE  = 2,
   parameter int RD_LAT      = 1,
   parameter int INIT_EN     = 1
) (
   input  logic                   forever_cpuclk,
   input  logic                   cpurst_b,
   input  logic                   pad_yy_icg_scan_en,
   input  logic                   init_start,
   output logic                   init_done,
   input  logic                   req_vld,
   output logic                   req_rdy,
   input  logic                   req_wr,
   input  logic [INDEX_WIDTH-1:0] req_idx,
   input  logic [DATA_WIDTH-1:0]  req_din,
   input  logic [DATA_WIDTH-1:0]  req_bwen,
   output logic                   rd_vld,
   output logic [DATA_WIDTH-1:0]  rd_dout
);

   localparam int BANK_W = bank_bits(BANK_NUM);
   localparam int SEL_W  = (BANK_W == 0) ? 1 : BANK_W;
   localparam int ROW_W  = INDEX_WIDTH - BANK_W;
   localparam logic [1:0] BUSY_LOAD = 2'(BANK_CYCLE - 1);

   state_e                            state_q, state_d;
   logic [ROW_W-1:0]                  row_cnt;
   logic [BANK_NUM-1:0][1:0]          busy_cnt;
   logic [SEL_W-1:0]                  bank_sel;
   logic [ROW_W-1:0]                  row_addr;
   logic                              in_init;
   logic                              acc;
   logic                              rd_acc;
   logic [BANK_NUM-1:0]               bank_cen;
   logic                              bank_gwen;
   logic [DATA_WIDTH-1:0]             bank_wen;
   logic [ROW_W-1:0]                  bank_a;
   logic [DATA_WIDTH-1:0]             bank_d;
   logic [BANK_NUM-1:0][DATA_WIDTH-1:0] bank_q;
   logic [RD_LAT:1]                   vld_q;
   logic [RD_LAT:0]                   vld_pipe;
   logic [SEL_W-1:0]                  sel_q;

   // Split the word index into bank select (low bits) and row address
   generate
      if (BANK_W == 0) begin : g_one_bank
         assign bank_sel = '0;
         assign row_addr = req_idx;
      end else begin : g_multi_bank
         assign bank_sel = req_idx[BANK_W-1:0];
         assign row_addr = req_idx[INDEX_WIDTH-1:BANK_W];
      end
   endgenerate

   assign in_init   = (state_q == ST_INIT);
   assign init_done = ~in_init;
   // init_start blocks acceptance so the restart never races a live access
   assign req_rdy   = ~in_init & (busy_cnt[bank_sel] == 2'd0) & ~init_start;
   assign acc       = req_vld & req_rdy;
   assign rd_acc    = acc & ~req_wr;

   // State register
   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         if (INIT_EN != 0) state_q <= ST_INIT;
         else              state_q <= ST_RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: leave INIT after the last row, re-enter on init_start
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_INIT: if (row_cnt == '1) state_d = ST_RUN;
         ST_RUN:  if (init_start)    state_d = ST_INIT;
         default: state_d = ST_INIT;
      endcase
   end

   // Zero-fill row counter; parked at 0 outside INIT so a restart begins at row 0
   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b)    row_cnt <= '0;
      else if (in_init) row_cnt <= row_cnt + ROW_W'(1);
      else              row_cnt <= '0;
   end

   // Per-bank busy counters enforce the minimum same-bank access spacing
   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         busy_cnt <= '0;
      end else begin
         for (int b = 0; b < BANK_NUM; b++) begin
            if (acc && (bank_sel == SEL_W'(b)))  busy_cnt[b] <= BUSY_LOAD;
            else if (busy_cnt[b] != 2'd0)         busy_cnt[b] <= busy_cnt[b] - 2'd1;
         end
      end
   end

   // Bank controls: INIT writes zeros to every bank, RUN targets one bank
   always_comb begin
      bank_cen  = '1;
      bank_gwen = ~req_wr;
      bank_wen  = req_bwen;
      bank_a    = row_addr;
      bank_d    = req_din;
      if (in_init) begin
         bank_cen  = '0;
         bank_gwen = 1'b0;
         bank_wen  = '0;
         bank_a    = row_cnt;
         bank_d    = '0;
      end else begin
         for (int b = 0; b < BANK_NUM; b++)
            if (acc && (bank_sel == SEL_W'(b))) bank_cen[b] = 1'b0;
      end
   end

   generate
      for (genvar b = 0; b < BANK_NUM; b++) begin : g_bank
         ct_l2cache_data_bank #(
            .DATA_WIDTH (DATA_WIDTH),
            .ROW_WIDTH  (ROW_W)
         ) u_bank (
            .clk                (forever_cpuclk),
            .pad_yy_icg_scan_en (pad_yy_icg_scan_en),
            .cen                (bank_cen[b]),
            .gwen               (bank_gwen),
            .wen                (bank_wen),
            .a                  (bank_a),
            .d                  (bank_d),
            .q                  (bank_q[b])
         );
      end
   endgenerate

   assign vld_pipe = {vld_q, rd_acc};

   // Read valid shift register and the bank select that steers the Q mux
   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         vld_q <= '0;
         sel_q <= '0;
      end else begin
         vld_q <= vld_pipe[RD_LAT-1:0];
         if (rd_acc) sel_q <= bank_sel;
      end
   end

   // Output stage: raw SRAM Q, or one extra flop that holds between reads
   generate
      if (RD_LAT == 1) begin : g_lat1
         assign rd_vld  = vld_pipe[1];
         assign rd_dout = vld_pipe[1] ? bank_q[sel_q] : '0;
      end else begin : g_lat2
         logic [DATA_WIDTH-1:0] dout_q;
         // Capture Q the cycle it appears
         always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
            if (!cpurst_b)        dout_q <= '0;
            else if (vld_pipe[1]) dout_q <= bank_q[sel_q];
         end
         assign rd_vld  = vld_pipe[RD_LAT];
         assign rd_dout = dout_q;
      end
   endgenerate

endmodule

// File: tb/tb_ct_l2cache_data_array_bank_ctrl.sv
// Bench: two controllers (read latency 1 and 2) share one stimulus stream and
// are compared each cycle against a cycle-indexed behavioural model.
module tb_ct_l2cache_data_array_bank_ctrl;

   localparam int DW   = 128;
   localparam int IW   = 6;
   localparam int BN   = 4;
   localparam int BC   = 2;
   localparam int ROWS = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          scan = 1'b0;
   logic          init_start = 1'b0;
   logic          req_vld = 1'b0;
   logic          req_wr = 1'b0;
   logic [IW-1:0] req_idx = '0;
   logic [DW-1:0] req_din = '0;
   logic [DW-1:0] req_bwen = '1;
   logic          rdy1, rdy2, done1, done2, rv1, rv2;
   logic [DW-1:0] rd1, rd2;

   always #5 clk = ~clk;

   ct_l2cache_data_array_bank_ctrl #(
      .DATA_WIDTH(DW), .INDEX_WIDTH(IW), .BANK_NUM(BN), .BANK_CYCLE(BC), .RD_LAT(1), .INIT_EN(1)
   ) u_dut1 (
      .forever_cpuclk(clk), .cpurst_b(rst_n), .pad_yy_icg_scan_en(scan), .init_start(init_start),
      .init_done(done1), .req_vld(req_vld), .req_rdy(rdy1), .req_wr(req_wr), .req_idx(req_idx),
      .req_din(req_din), .req_bwen(req_bwen), .rd_vld(rv1), .rd_dout(rd1)
   );

   ct_l2cache_data_array_bank_ctrl #(
      .DATA_WIDTH(DW), .INDEX_WIDTH(IW), .BANK_NUM(BN), .BANK_CYCLE(BC), .RD_LAT(2), .INIT_EN(1)
   ) u_dut2 (
      .forever_cpuclk(clk), .cpurst_b(rst_n), .pad_yy_icg_scan_en(scan), .init_start(init_start),
      .init_done(done2), .req_vld(req_vld), .req_rdy(rdy2), .req_wr(req_wr), .req_idx(req_idx),
      .req_din(req_din), .req_bwen(req_bwen), .rd_vld(rv2), .rd_dout(rd2)
   );

   int checks = 0;
   int failures = 0;

   // Reference model: word memory, per-bank last-accept cycle, reads keyed by accept cycle
   logic [DW-1:0] mem [64];
   bit            run;
   int            init_left;
   int            cyc = 0;
   int            last_acc [BN];
   bit            rd_v [int];
   logic [DW-1:0] rd_d [int];
   logic [DW-1:0] last2;
   bit            m_acc;

   task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      run = 1'b0;
      init_left = ROWS;
      for (int i = 0; i < 64; i++) mem[i] = '0;
      for (int i = 0; i < BN; i++) last_acc[i] = -100;
      rd_v.delete();
      rd_d.delete();
      last2 = '0;
   endtask

   // Assert reset (checked immediately, asynchronous), release one edge later
   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk("rst_rdy1", rdy1, 0);  chk("rst_rdy2", rdy2, 0);
      chk("rst_done1", done1, 0); chk("rst_done2", done2, 0);
      chk("rst_vld1", rv1, 0);   chk("rst_vld2", rv2, 0);
      chk("rst_dout1", rd1, 0);  chk("rst_dout2", rd2, 0);
      model_reset();
      @(posedge clk); #1;
      rst_n = 1'b1;
      cyc++;
   endtask

   // One clock cycle: drive, check outputs mid-cycle, advance the model
   task automatic step(input bit v, input bit w, input int idx, input logic [DW-1:0] din,
                       input logic [DW-1:0] bwen, input bit st);
      int b;
      bit exp_rdy, e1, e2;
      req_vld = v; req_wr = w; req_idx = idx[IW-1:0];
      req_din = din; req_bwen = bwen; init_start = st;
      #4;
      b = idx % BN;
      exp_rdy = run && ((cyc - last_acc[b]) >= BC) && !st;
      chk("req_rdy1", rdy1, exp_rdy);
      chk("req_rdy2", rdy2, exp_rdy);
      chk("init_done1", done1, run);
      chk("init_done2", done2, run);
      e1 = rd_v.exists(cyc - 1);
      e2 = rd_v.exists(cyc - 2);
      chk("rd_vld1", rv1, e1);
      if (e1) chk("rd_dout1", rd1, rd_d[cyc - 1]);
      chk("rd_vld2", rv2, e2);
      if (e2) last2 = rd_d[cyc - 2];
      chk("rd_dout2", rd2, last2);
      m_acc = v && exp_rdy;
      if (m_acc) begin
         last_acc[b] = cyc;
         if (w) mem[idx] = (mem[idx] & bwen) | (din & ~bwen);
         else begin
            rd_v[cyc] = 1'b1;
            rd_d[cyc] = mem[idx];
         end
      end
      if (!run) begin
         init_left--;
         if (init_left == 0) run = 1'b1;
      end else if (st) begin
         run = 1'b0;
         init_left = ROWS;
         for (int i = 0; i < 64; i++) mem[i] = '0;
      end
      @(posedge clk); #1;
      cyc++;
   endtask

   // Hold a request until accepted, bounded
   task automatic issue(input bit w, input int idx, input logic [DW-1:0] din, input logic [DW-1:0] bwen);
      int n = 0;
      do begin
         step(1'b1, w, idx, din, bwen, 1'b0);
         n++;
      end while (!m_acc && n < 24);
      chk("accepted", m_acc, 1);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, $urandom_range(0, 63), '0, '1, 1'b0);
   endtask

   initial begin
      logic [DW-1:0] a5;
      logic [DW-1:0] upper_keep;
      a5 = {16{8'hA5}};
      upper_keep = {{64{1'b1}}, {64{1'b0}}};

      #1;
      do_reset();
      idle(ROWS);                                   // zero-fill window
      for (int i = 0; i < 64; i++) issue(1'b0, i, '0, '1);
      idle(3);

      issue(1'b1, 5, a5, '0);                       // full write
      issue(1'b0, 5, '0, '1);
      idle(3);
      issue(1'b1, 5, '0, upper_keep);               // partial write, lower half only
      issue(1'b0, 5, '0, '1);
      idle(3);

      issue(1'b0, 4, '0, '1);                       // same-bank back-to-back stalls
      issue(1'b0, 8, '0, '1);
      idle(3);
      for (int i = 4; i < 8; i++) issue(1'b0, i, '0, '1);
      idle(4);

      for (int i = 0; i < 400; i++)
         step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 63),
              {$urandom, $urandom, $urandom, $urandom},
              ($urandom_range(0, 2) == 0) ? '0 : {$urandom, $urandom, $urandom, $urandom},
              $urandom_range(0, 99) == 0);
      idle(20);

      issue(1'b1, 9, 128'h1, '0);                   // re-init clears written data
      step(1'b0, 1'b0, 0, '0, '1, 1'b1);
      idle(ROWS);
      issue(1'b0, 9, '0, '1);
      idle(3);

      step(1'b0, 1'b0, 0, '0, '1, 1'b1);            // reset in the middle of INIT
      idle(5);
      do_reset();
      idle(ROWS);
      issue(1'b0, 9, '0, '1);
      issue(1'b0, 2, '0, '1);
      idle(4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
